// File: rtl/wiegand_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_pkg
// Brief    : Shared constants, FSM encoding and parity helper for Wiegand RX.
// Revision : 1.0
// ============================================================================
package wiegand_pkg;

  localparam int WIG_FRAME_BITS = 26;
  localparam int WIG_BIT0_IDX   = 0;
  localparam int WIG_BIT1_IDX   = 1;

  localparam int WIG_PAR_HI_MSB = 24;
  localparam int WIG_PAR_HI_LSB = 13;
  localparam int WIG_PAR_LO_MSB = 12;
  localparam int WIG_PAR_LO_LSB = 1;

  typedef enum logic [1:0] {
    WIG_IDLE  = 2'd0,
    WIG_PULSE = 2'd1,
    WIG_GAP   = 2'd2,
    WIG_CLOSE = 2'd3
  } wig_state_e;

  // Leading bit gives even parity over the upper half, trailing bit odd over the lower.
  function automatic logic wig_parity_bad(input logic [WIG_FRAME_BITS-1:0] d);
    logic hi_bad;
    logic lo_bad;
    hi_bad = d[WIG_FRAME_BITS-1] ^ (^d[WIG_PAR_HI_MSB:WIG_PAR_HI_LSB]);
    lo_bad = ~(d[0] ^ (^d[WIG_PAR_LO_MSB:WIG_PAR_LO_LSB]));
    return hi_bad | lo_bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wiegand_rx_frame_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_line_filter
// Brief    : Two-flop synchronizer plus low-pulse deglitch for one Wiegand line.
// Revision : 1.0
// ============================================================================
module wiegand_line_filter #(
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_sync,
  output logic asserted,
  output logic glitch
);

  localparam int              CW           = $clog2(GLITCH_CYCLES + 1);
  localparam logic [CW-1:0]   c_glitch_max = CW'(GLITCH_CYCLES);

  logic          r_meta;
  logic          r_sync;
  logic          r_armed;
  logic [CW-1:0] r_low_cnt;

  // Synchronizer resets low so a line held low through reset never arms until it goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_armed   <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_meta <= line_raw;
      r_sync <= r_meta;
      if (r_sync) begin
        r_armed   <= 1'b1;
        r_low_cnt <= '0;
      end else if (r_armed && (r_low_cnt != c_glitch_max)) begin
        r_low_cnt <= r_low_cnt + 1'b1;
      end
    end
  end

  assign line_sync = r_sync;
  assign asserted  = (r_low_cnt == c_glitch_max);
  assign glitch    = r_sync && (r_low_cnt != '0) && (r_low_cnt != c_glitch_max);

endmodule
`default_nettype wire

// File: rtl/wiegand_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : wiegand_rx_frame
// Brief    : Wiegand D0/D1 receiver: deglitch, frame assembly, timeout close,
//            W26 parity check and ready/ack result holding.
//            Optional macro WIEGAND_RX_GLITCH_CNT_EN adds the glitch_cnt port.
// Revision : 1.0
// ============================================================================
module wiegand_rx_frame
  import wiegand_pkg::*;
#(
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FRAME_BITS     = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wig_d,
  input  logic        frame_ack,
  output logic [25:0] frame_data,
  output logic        frame_ready,
  output logic        irq_n,
  output logic        parity_err,
  output logic        len_err,
  output logic        overrun
`ifdef WIEGAND_RX_GLITCH_CNT_EN
  ,
  output logic [7:0]  glitch_cnt
`endif
);

  localparam int            TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] c_timeout_last = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    c_frame_bits   = 5'(FRAME_BITS);

  localparam logic [1:0] c_idle  = WIG_IDLE;
  localparam logic [1:0] c_pulse = WIG_PULSE;
  localparam logic [1:0] c_gap   = WIG_GAP;
  localparam logic [1:0] c_close = WIG_CLOSE;

  logic [1:0] w_sync;
  logic [1:0] w_asrt;
  logic [1:0] w_glitch;

  for (genvar i = 0; i < 2; i++) begin : g_line
    wiegand_line_filter #(
      .GLITCH_CYCLES(GLITCH_CYCLES)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .line_raw (wig_d[i]),
      .line_sync(w_sync[i]),
      .asserted (w_asrt[i]),
      .glitch   (w_glitch[i])
    );
  end

  logic [1:0]    r_state;
  logic [31:0]   r_shift;
  logic [4:0]    r_count;
  logic          r_bad;
  logic [TW-1:0] r_timer;

  logic w_any;
  logic w_both;
  logic w_bit;
  logic w_close;
  logic w_len_bad;
  logic w_par_bad;

  assign w_any     = |w_asrt;
  assign w_both    = w_asrt[WIG_BIT0_IDX] & w_asrt[WIG_BIT1_IDX];
  assign w_bit     = w_asrt[WIG_BIT1_IDX];
  assign w_close   = (r_state == c_close);
  assign w_len_bad = r_bad || (r_count != c_frame_bits);
  assign w_par_bad = !w_len_bad && wig_parity_bad(r_shift[WIG_FRAME_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_shift <= '0;
      r_count <= '0;
      r_bad   <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        c_idle, c_gap: begin
          if (w_any) begin
            // Simultaneous D0/D1 is undecodable: poison the frame instead of guessing a bit.
            if (w_both) begin
              r_bad <= 1'b1;
            end else begin
              r_shift <= {r_shift[30:0], w_bit};
              if (r_count != 5'd31) begin
                r_count <= r_count + 5'd1;
              end
            end
            r_state <= c_pulse;
          end else if (r_state == c_gap) begin
            if (r_timer == c_timeout_last) begin
              r_state <= c_close;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        c_pulse: begin
          if (&w_sync) begin
            r_timer <= '0;
            r_state <= c_gap;
          end
        end
        default: begin
          r_shift <= '0;
          r_count <= '0;
          r_bad   <= 1'b0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  logic [25:0] r_frame_data;
  logic        r_ready;
  logic        r_parity_err;
  logic        r_len_err;
  logic        r_overrun;

  // A close coinciding with ack takes the slot the ack is freeing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_data <= '0;
      r_ready      <= 1'b0;
      r_parity_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_close && (!r_ready || frame_ack)) begin
      r_frame_data <= r_shift[WIG_FRAME_BITS-1:0];
      r_ready      <= 1'b1;
      r_parity_err <= w_par_bad;
      r_len_err    <= w_len_bad;
      r_overrun    <= 1'b0;
    end else if (w_close) begin
      r_overrun <= 1'b1;
    end else if (frame_ack && r_ready) begin
      r_ready      <= 1'b0;
      r_parity_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_ready = r_ready;
  assign irq_n       = ~r_ready;
  assign parity_err  = r_parity_err;
  assign len_err     = r_len_err;
  assign overrun     = r_overrun;

`ifdef WIEGAND_RX_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;
  logic [1:0] w_glitch_inc;
  logic [8:0] w_glitch_sum;

  assign w_glitch_inc = {1'b0, w_glitch[0]} + {1'b0, w_glitch[1]}
                      + {1'b0, w_both && ((r_state == c_idle) || (r_state == c_gap))};
  assign w_glitch_sum = {1'b0, r_glitch_cnt} + {7'd0, w_glitch_inc};

  always_ff @(posedge clk) begin
    if (rst || frame_ack) begin
      r_glitch_cnt <= '0;
    end else begin
      r_glitch_cnt <= w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  logic w_unused_glitch;
  assign w_unused_glitch = ^w_glitch;
`endif

  logic w_unused_shift;
  assign w_unused_shift = ^r_shift[31:WIG_FRAME_BITS];

endmodule
`default_nettype wire
